// File: rtl/axi_stream_skid_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_skid_receiver_if
// Brief    : AXI-Stream bundle with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_stream_skid_receiver_if #(
    parameter int BYTE_WIDTH = 4,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic                    tvalid;
    logic                    tready;
    logic [8*BYTE_WIDTH-1:0] tdata;
    logic [BYTE_WIDTH-1:0]   tstrb;
    logic [BYTE_WIDTH-1:0]   tkeep;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axi_stream_skid_receiver.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_skid_receiver
// Brief    : Two-entry skid register slice with sticky upstream-violation flag.
// Revision : 1.0 - initial release
// ============================================================================
module axi_stream_skid_receiver #(
    parameter int BYTE_WIDTH = 4,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    axi_stream_skid_receiver_if.slave        s_axis,
    axi_stream_skid_receiver_if.master       m_axis,
    output logic                             protocol_error_o
);
    localparam int DATA_W    = 8 * BYTE_WIDTH;
    localparam int PAYLOAD_W = DATA_W + 2 * BYTE_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PAYLOAD_W-1:0]   out_q, out_d;
    logic [PAYLOAD_W-1:0]   skid_q, skid_d;
    logic [PAYLOAD_W-1:0]   s_payload;
    logic [PAYLOAD_W-1:0]   hist_payload_q;
    logic                   stall_q;
    logic                   err_q, err_d;
    logic                   s_ready;
    logic                   accept;
    logic                   take;
    logic                   strb_err;
    logic                   hold_err;

    assign s_payload = {s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tlast,
                        s_axis.tid, s_axis.tdest, s_axis.tuser};

    // Ready depends only on state and reset, never on downstream tready.
    assign s_ready = (state_q != ST_FULL) && !reset_i;
    assign accept  = s_axis.tvalid && s_ready;
    assign take    = (state_q != ST_EMPTY) && m_axis.tready;

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = (state_q != ST_EMPTY);
    assign {m_axis.tdata, m_axis.tstrb, m_axis.tkeep, m_axis.tlast,
            m_axis.tid, m_axis.tdest, m_axis.tuser} = out_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_d   = s_payload;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept && !take) begin
                    skid_d  = s_payload;
                    state_d = ST_FULL;
                end else if (take && !accept) begin
                    state_d = ST_EMPTY;
                end else if (accept && take) begin
                    out_d   = s_payload;
                end
            end
            ST_FULL: begin
                if (take) begin
                    out_d   = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // A stalled beat must stay valid and unchanged until it is accepted.
    assign strb_err = s_axis.tvalid && (|(s_axis.tstrb & ~s_axis.tkeep));
    assign hold_err = stall_q && (!s_axis.tvalid || (s_payload != hist_payload_q));
    assign err_d    = err_q | strb_err | hold_err;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_q        <= 1'b0;
            hist_payload_q <= '0;
            err_q          <= 1'b0;
        end else begin
            stall_q        <= s_axis.tvalid && !s_ready;
            hist_payload_q <= s_payload;
            err_q          <= err_d;
        end
    end

    assign protocol_error_o = err_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_stream_skid_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_stream_skid_receiver
// Brief    : Directed vector table plus corner-case sequences and a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_stream_skid_receiver;
    logic clk = 1'b0;
    logic reset;
    logic perr;

    always #5 clk = ~clk;

    axi_stream_skid_receiver_if #(.BYTE_WIDTH(4)) s_if ();
    axi_stream_skid_receiver_if #(.BYTE_WIDTH(4)) m_if ();

    axi_stream_skid_receiver #(.BYTE_WIDTH(4)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .s_axis           (s_if),
        .m_axis           (m_if),
        .protocol_error_o (perr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic [2:0]  s_liu;
        logic        mr;
        logic        e_sr;
        logic        e_mv;
        logic        chk;
        logic [31:0] e_d;
        logic [2:0]  e_liu;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic sv, logic [31:0] sd, logic [2:0] s_liu, logic mr,
                                logic e_sr, logic e_mv, logic chk, logic [31:0] e_d,
                                logic [2:0] e_liu, logic e_err);
        vec_t v;
        v.sv = sv; v.sd = sd; v.s_liu = s_liu; v.mr = mr;
        v.e_sr = e_sr; v.e_mv = e_mv; v.chk = chk; v.e_d = e_d;
        v.e_liu = e_liu; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] liu);
        s_if.tvalid = v;
        s_if.tdata  = d;
        s_if.tstrb  = 4'hF;
        s_if.tkeep  = 4'hF;
        s_if.tlast  = liu[2];
        s_if.tid    = liu[1];
        s_if.tdest  = 1'b0;
        s_if.tuser  = liu[0];
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        drive(1'b0, 32'h0, 3'b000);
        m_if.tready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Fill to FULL with two beats and leave a third stalled upstream.
    task automatic fill_full(input logic [31:0] base);
        m_if.tready = 1'b0;
        cyc(); drive(1'b1, base,     3'b000);
        cyc(); drive(1'b1, base + 1, 3'b000);
        cyc(); drive(1'b1, base + 2, 3'b000);
    endtask

    logic [32:0] exp_q[$];
    logic [32:0] front;
    logic        pending;
    logic        prev_stall;
    logic [31:0] prev_data;
    int          n_acc, n_recv, cycles;
    logic        acc, tk;

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 3'b000);
        m_if.tready = 1'b0;
        #12;
        chk1("reset_s_tready", s_if.tready, 1'b0);
        chk1("reset_m_tvalid", m_if.tvalid, 1'b0);
        chk32("reset_m_tdata", m_if.tdata, 32'h0);
        chk1("reset_perr", perr, 1'b0);
        cyc();
        reset = 1'b0;

        // Backpressure: A1,A2 buffered, A3 held upstream, then drained in order.
        vecs.push_back(mk(0, 32'h0,  3'b000, 0, 1, 0, 0, 32'h0,  3'b000, 0));
        vecs.push_back(mk(1, 32'hA1, 3'b010, 0, 1, 0, 0, 32'h0,  3'b000, 0));
        vecs.push_back(mk(1, 32'hA2, 3'b101, 0, 1, 1, 1, 32'hA1, 3'b010, 0));
        vecs.push_back(mk(1, 32'hA3, 3'b111, 0, 0, 1, 1, 32'hA1, 3'b010, 0));
        vecs.push_back(mk(1, 32'hA3, 3'b111, 1, 0, 1, 1, 32'hA1, 3'b010, 0));
        vecs.push_back(mk(1, 32'hA3, 3'b111, 1, 1, 1, 1, 32'hA2, 3'b101, 0));
        vecs.push_back(mk(0, 32'h0,  3'b000, 1, 1, 1, 1, 32'hA3, 3'b111, 0));
        vecs.push_back(mk(0, 32'h0,  3'b000, 1, 1, 0, 0, 32'h0,  3'b000, 0));
        // Streaming 0..15 at full rate, one cycle of latency.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] prv;
            prv = i - 1;
            vecs.push_back(mk(1, i, {(i == 15), 1'b0, i[0]}, 1, 1, (i != 0), (i != 0),
                              prv, {2'b00, prv[0]}, 0));
        end
        vecs.push_back(mk(0, 32'h0, 3'b000, 1, 1, 1, 1, 32'd15, 3'b101, 0));
        vecs.push_back(mk(0, 32'h0, 3'b000, 1, 1, 0, 0, 32'h0,  3'b000, 0));

        foreach (vecs[i]) begin
            cyc();
            drive(vecs[i].sv, vecs[i].sd, vecs[i].s_liu);
            m_if.tready = vecs[i].mr;
            #1;
            chk1("vec_s_tready", s_if.tready, vecs[i].e_sr);
            chk1("vec_m_tvalid", m_if.tvalid, vecs[i].e_mv);
            chk1("vec_perr", perr, vecs[i].e_err);
            if (vecs[i].chk) begin
                chk32("vec_m_tdata", m_if.tdata, vecs[i].e_d);
                chk32("vec_m_liu", {29'b0, m_if.tlast, m_if.tid, m_if.tuser},
                      {29'b0, vecs[i].e_liu});
            end
        end

        // Valid withdrawn while stalled.
        fill_full(32'hB0);
        cyc(); drive(1'b0, 32'h0, 3'b000);
        #1;
        chk1("withdraw_before_edge", perr, 1'b0);
        cyc();
        chk1("withdraw_perr_set", perr, 1'b1);
        cyc(); cyc();
        chk1("withdraw_perr_sticky", perr, 1'b1);
        do_reset();
        #1;
        chk1("perr_cleared_by_reset", perr, 1'b0);

        // Payload changed while stalled.
        fill_full(32'hC0);
        cyc(); drive(1'b1, 32'hC7, 3'b000);
        cyc();
        chk1("payload_change_perr", perr, 1'b1);
        do_reset();

        // Strobe must be a subset of keep.
        m_if.tready = 1'b1;
        cyc(); drive(1'b1, 32'h11, 3'b000); s_if.tstrb = 4'b0001; s_if.tkeep = 4'b0011;
        cyc(); drive(1'b0, 32'h0, 3'b000);
        #1;
        chk1("strb_subset_ok", perr, 1'b0);
        cyc(); drive(1'b1, 32'h22, 3'b000); s_if.tstrb = 4'b0100; s_if.tkeep = 4'b0011;
        cyc(); drive(1'b0, 32'h0, 3'b000);
        #1;
        chk1("strb_not_in_keep", perr, 1'b1);
        do_reset();

        // Reset asserted between edges while FULL.
        fill_full(32'hD0);
        #1;
        chk1("full_s_tready", s_if.tready, 1'b0);
        chk1("full_m_tvalid", m_if.tvalid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1("async_rst_m_tvalid", m_if.tvalid, 1'b0);
        chk1("async_rst_s_tready", s_if.tready, 1'b0);
        chk32("async_rst_m_tdata", m_if.tdata, 32'h0);
        cyc();
        reset = 1'b0;
        drive(1'b0, 32'h0, 3'b000);
        m_if.tready = 1'b1;
        cyc();
        chk1("post_rst_s_tready", s_if.tready, 1'b1);
        chk1("post_rst_m_tvalid", m_if.tvalid, 1'b0);
        drive(1'b1, 32'hE1, 3'b000);
        cyc(); drive(1'b0, 32'h0, 3'b000);
        #1;
        chk1("post_rst_beat_valid", m_if.tvalid, 1'b1);
        chk32("post_rst_beat_data", m_if.tdata, 32'hE1);
        cyc();
        chk1("no_stale_beat", m_if.tvalid, 1'b0);

        // Random valid/ready with scoreboard and stall-stability checks.
        pending = 1'b0; prev_stall = 1'b0; prev_data = '0;
        n_acc = 0; n_recv = 0; cycles = 0;
        while (n_recv < 1000 && cycles < 20000) begin
            cyc();
            cycles++;
            if (!pending) begin
                if (n_acc < 1000 && $urandom_range(1, 0) == 1) begin
                    logic [31:0] d;
                    d = $urandom;
                    drive(1'b1, d, {d[0], 2'b00});
                end else begin
                    drive(1'b0, 32'h0, 3'b000);
                end
            end
            m_if.tready = ($urandom_range(1, 0) == 1);
            #1;
            if (prev_stall) chk32("stall_stable", m_if.tdata, prev_data);
            acc = s_if.tvalid && s_if.tready;
            tk  = m_if.tvalid && m_if.tready;
            if (tk) begin
                if (exp_q.size() == 0) begin
                    chk1("sb_unexpected_beat", 1'b1, 1'b0);
                end else begin
                    front = exp_q.pop_front();
                    chk32("sb_data", m_if.tdata, front[31:0]);
                    chk1("sb_last", m_if.tlast, front[32]);
                end
                n_recv++;
            end
            if (acc) begin
                exp_q.push_back({s_if.tlast, s_if.tdata});
                n_acc++;
            end
            pending    = s_if.tvalid && !acc;
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
        end
        chk1("random_completed", (n_recv == 1000), 1'b1);
        chk1("random_perr_clear", perr, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi_stream_skid_receiver.md
# axi_stream_skid_receiver

AXI-Stream slave-side receiver and register slice: accepts beats from an upstream AXI-Stream master, stores them in a two-entry skid buffer and re-presents them on a downstream master port. Full throughput, no combinational path from m_tready to s_tready. It also flags upstream handshake violations as a sticky synthesizable error bit. It sits at block boundaries wherever a stream enters a timing-critical region.

## Interface
- byte_width, 4, TDATA width in bytes; TSTRB/TKEEP are byte_width bits
- id_width, 1, TID width (minimum 1)
- dest_width, 1, TDEST width (minimum 1)
- user_width, 1, TUSER width (minimum 1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- s_tvalid, s_tready  in/out  1  upstream handshake
- s_tdata  in  8*byte_width; s_tstrb, s_tkeep  in  byte_width; s_tlast  in  1; s_tid  in  id_width; s_tdest  in  dest_width; s_tuser  in  user_width
- m_tvalid, m_tready  out/in  1  downstream handshake
- m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  out  same widths as s_*
- protocol_error  out  1  sticky upstream-violation flag

## Operation
- Payload = {tdata, tstrb, tkeep, tlast, tid, tdest, tuser}, always moved as a unit.
- Accept = s_tvalid && s_tready; take = m_tvalid && m_tready.
- Two registers: OUT (drives m_*), SKID (overflow). State EMPTY / BUSY / FULL.
- EMPTY: accept -> OUT <= s payload, BUSY.
- BUSY: accept && !take -> SKID <= s payload, FULL; take && !accept -> EMPTY; accept && take -> OUT <= s payload, stay BUSY; neither -> hold.
- FULL: take -> OUT <= SKID, BUSY; else hold. No accept possible in FULL.
- m_tvalid = (state != EMPTY), decoded from state register only.
- s_tready = (state != FULL) && !reset; decoded from state register and reset only.
- Beats leave in arrival order; none dropped or duplicated; payload passes bit-exact.
- protocol_error set (never cleared except by reset) when any of:
  - previous cycle had s_tvalid && !s_tready and current s_tvalid is 0 (valid withdrawn);
  - previous cycle had s_tvalid && !s_tready and any current payload field differs from previous cycle;
  - s_tvalid && (s_tstrb & ~s_tkeep) != 0.
- Violating beats are still buffered/accepted per normal rules; the flag is diagnostic only.

## Timing
- Reset (async assert, sync release at next clk): state EMPTY, OUT/SKID and all m_* payload 0, m_tvalid 0, s_tready 0 while reset high, protocol_error 0, violation history cleared.
- First cycle after reset release: s_tready 1.
- Latency: beat accepted at edge N is on m_* with m_tvalid 1 after edge N.
- Throughput: one beat/cycle sustained while m_tready held 1.
- s_tready falls the cycle after a beat is accepted into SKID; rises the cycle after the FULL-state take.
- m_* payload stable while m_tvalid && !m_tready (buffer obeys the stability rules it checks).
- protocol_error rises the cycle after the violating edge (registered); strb/keep check also registered.
- Reset mid-transfer: all buffered beats discarded, no partial beat emitted.

## Test plan
- Streaming: m_tready=1, send 16 beats tdata=0..15 back-to-back -> m_tdata 0..15 one cycle delayed, s_tready never 0, protocol_error 0.
- Backpressure: m_tready=0, send beats 0xA1,0xA2,0xA3 -> s_tready drops after 0xA2 accepted, 0xA3 held upstream; release m_tready -> A1,A2,A3 in order with tlast/tid/tuser intact.
- Random: random s_tvalid and m_tready (50%) over 1000 beats -> scoreboard exact order match, m_* stable under stall.
- Violations: upstream drops s_tvalid while s_tready=0 -> protocol_error=1 next cycle, stays 1; separate run with tkeep=4'b0011, tstrb=4'b0100 -> protocol_error=1.
- Reset mid-operation: fill to FULL, assert reset asynchronously between edges -> m_tvalid 0, s_tready 0 immediately; release -> EMPTY, s_tready 1 next cycle, no stale beats.
